serial_frame_tx: RTL and testbench

- Transmit end of the team's three-wire serial display link: data, shift clock and latch strobe.
- Accepts a parallel WIDTH-bit word over a valid/ready handshake. Shifts it out MSB-first on sdata with a generated sclk, then pulses latch so the far-end shift register captures the word.
- Sits in front of the display/shift-register receiver chain; one frame per accepted word.

---
 rtl/serial_frame_tx.sv | 122 ++++++++++++
 tb/tb_serial_frame_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Three-wire serial display link transmitter: shifts a parallel word out on
// sdata/sclk, then pulses latch so the far-end shift register captures it.
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    LATCH
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [PW-1:0]    r_phase;
  logic [PW-1:0]    w_phase_next;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_phase_last;
  logic             w_cur_bit;

  assign w_phase_last = (r_phase == PHASE_LAST);
  assign w_cur_bit    = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_phase   <= w_phase_next;
      r_bit_cnt <= w_bit_next;
      r_shreg   <= w_shreg_next;
      r_done    <= w_done_next;
    end
  end

  // Every state lasts CLK_DIV cycles; the phase counter restarts on each change.
  always_comb begin
    w_next_state = r_state;
    w_phase_next = r_phase + PW'(1);
    w_bit_next   = r_bit_cnt;
    w_shreg_next = r_shreg;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_phase_next = '0;
        if (valid) begin
          w_shreg_next = data_in;
          w_bit_next   = '0;
          w_next_state = LOW;
        end
      end
      LOW: begin
        if (w_phase_last) begin
          w_phase_next = '0;
          w_next_state = HIGH;
        end
      end
      HIGH: begin
        if (w_phase_last) begin
          w_phase_next = '0;
          w_shreg_next = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);
          w_bit_next   = r_bit_cnt + BW'(1);
          w_next_state = (r_bit_cnt == BIT_LAST) ? LATCH : LOW;
        end
      end
      LATCH: begin
        if (w_phase_last) begin
          w_phase_next = '0;
          w_done_next  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_phase_next = '0;
        w_next_state = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so valid/data_in never reach a pin.
  assign ready = (r_state == IDLE);
  assign busy  = (r_state != IDLE);
  assign sclk  = (r_state == HIGH);
  assign latch = (r_state == LATCH);
  assign sdata = ((r_state == LOW) || (r_state == HIGH)) ? w_cur_bit : 1'b0;
  assign done  = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default, LSB-first/fast and 16-bit instances.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  logic clk;
  logic rst;
  logic [7:0]  data0, data1;
  logic [15:0] data2;
  logic valid0, valid1, valid2;
  logic ready0, sdata0, sclk0, latch0, busy0, done0;
  logic ready1, sdata1, sclk1, latch1, busy1, done1;
  logic ready2, sdata2, sclk2, latch2, busy2, done2;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx0;
  logic [7:0] cap0;
  int latchCnt0 = 0;

  serial_frame_tx #(.WIDTH(8), .CLK_DIV(2), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data0), .valid(valid0), .ready(ready0),
    .sdata(sdata0), .sclk(sclk0), .latch(latch0), .busy(busy0), .done(done0)
  );

  serial_frame_tx #(.WIDTH(8), .CLK_DIV(1), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .valid(valid1), .ready(ready1),
    .sdata(sdata1), .sclk(sclk1), .latch(latch1), .busy(busy1), .done(done1)
  );

  serial_frame_tx #(.WIDTH(16), .CLK_DIV(3), .LSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .data_in(data2), .valid(valid2), .ready(ready2),
    .sdata(sdata2), .sclk(sclk2), .latch(latch2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Behavioural far-end receiver for the default instance.
  always @(posedge sclk0) rx0 <= {rx0[6:0], sdata0};
  always @(posedge latch0) begin
    cap0      <= rx0;
    latchCnt0 <= latchCnt0 + 1;
  end

  task automatic accept(input int sel, input logic [15:0] d);
    case (sel)
      0: begin data0 = d[7:0]; valid0 = 1'b1; end
      1: begin data1 = d[7:0]; valid1 = 1'b1; end
      default: begin data2 = d; valid2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  // Called #1 after the acceptance edge; returns #1 after the edge that raises done.
  task automatic measure(input int sel, input bit toggle, output int doneAt,
                         output int busyCyc, output int rises, output int minHigh,
                         output int maxHigh, output int latchLen,
                         output logic [15:0] bits, output int overlap);
    logic s, d, l, dn, b, prev;
    int run;
    doneAt = -1; busyCyc = 0; rises = 0; minHigh = 1000; maxHigh = 0;
    latchLen = 0; bits = '0; overlap = 0; prev = 1'b0; run = 0;
    for (int n = 1; n <= 400; n++) begin
      case (sel)
        0: begin s = sclk0; d = sdata0; l = latch0; dn = done0; b = busy0; end
        1: begin s = sclk1; d = sdata1; l = latch1; dn = done1; b = busy1; end
        default: begin s = sclk2; d = sdata2; l = latch2; dn = done2; b = busy2; end
      endcase
      if (dn) begin
        doneAt = n;
        break;
      end
      if (b) busyCyc++;
      if (s) begin
        run++;
        if (!prev) begin
          rises++;
          bits = {bits[14:0], d};
        end
      end else if (prev) begin
        if (run < minHigh) minHigh = run;
        if (run > maxHigh) maxHigh = run;
        run = 0;
      end
      if (l) latchLen++;
      if (l && s) overlap++;
      prev = s;
      if (toggle) data0 = data0 ^ 8'h66;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", ready0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk got %b expected 0", sclk0); end
    checks++; if (sdata0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sdata got %b expected 0", sdata0); end
    checks++; if (latch0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_latch got %b expected 0", latch0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done0); end
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (ready0 !== 1'b1 || busy0 !== 1'b0 || sclk0 !== 1'b0 || sdata0 !== 1'b0 || latch0 !== 1'b0 || done0 !== 1'b0) bad++;
      if (ready1 !== 1'b1 || busy1 !== 1'b0 || sclk1 !== 1'b0 || sdata1 !== 1'b0 || latch1 !== 1'b0 || done1 !== 1'b0) bad++;
      if (ready2 !== 1'b1 || busy2 !== 1'b0 || sclk2 !== 1'b0 || sdata2 !== 1'b0 || latch2 !== 1'b0 || done2 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL idle_outputs got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_basic();
    int doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, overlap;
    logic [15:0] bits;
    accept(0, 16'h00A5);
    checks++; if (ready0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop got %b expected 0", ready0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b expected 1", busy0); end
    measure(0, 1'b0, doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, bits, overlap);
    checks++; if (doneAt !== 35) begin errors++; $display("[TB] FAIL basic_done_at got %0d expected 35", doneAt); end
    checks++; if (busyCyc !== 34) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d expected 34", busyCyc); end
    checks++; if (rises !== 8) begin errors++; $display("[TB] FAIL basic_sclk_rises got %0d expected 8", rises); end
    checks++; if (minHigh !== 2 || maxHigh !== 2) begin errors++; $display("[TB] FAIL basic_sclk_high got %0d..%0d expected 2..2", minHigh, maxHigh); end
    checks++; if (latchLen !== 2) begin errors++; $display("[TB] FAIL basic_latch_len got %0d expected 2", latchLen); end
    checks++; if (bits !== 16'h00A5) begin errors++; $display("[TB] FAIL basic_bits got %h expected 00a5", bits); end
    checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL basic_overlap got %0d expected 0", overlap); end
    checks++; if (cap0 !== 8'hA5) begin errors++; $display("[TB] FAIL basic_rx got %h expected a5", cap0); end
  endtask

  task automatic test_lsb_fast();
    int doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, overlap;
    logic [15:0] bits;
    accept(1, 16'h0001);
    measure(1, 1'b0, doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, bits, overlap);
    checks++; if (busyCyc !== 17) begin errors++; $display("[TB] FAIL lsb_busy_cycles got %0d expected 17", busyCyc); end
    checks++; if (doneAt !== 18) begin errors++; $display("[TB] FAIL lsb_done_at got %0d expected 18", doneAt); end
    checks++; if (rises !== 8) begin errors++; $display("[TB] FAIL lsb_sclk_rises got %0d expected 8", rises); end
    checks++; if (bits !== 16'h0080) begin errors++; $display("[TB] FAIL lsb_bits got %h expected 0080", bits); end
    checks++; if (latchLen !== 1) begin errors++; $display("[TB] FAIL lsb_latch_len got %0d expected 1", latchLen); end
    checks++; if (minHigh !== 1 || maxHigh !== 1) begin errors++; $display("[TB] FAIL lsb_sclk_high got %0d..%0d expected 1..1", minHigh, maxHigh); end
  endtask

  task automatic test_back_to_back();
    int doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, overlap;
    logic [15:0] bits;
    data0 = 8'h3C;
    valid0 = 1'b1;
    @(posedge clk); #1;
    measure(0, 1'b1, doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, bits, overlap);
    checks++; if (doneAt !== 35) begin errors++; $display("[TB] FAIL b2b_done1_at got %0d expected 35", doneAt); end
    checks++; if (cap0 !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_rx1 got %h expected 3c", cap0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_at_done got %b expected 1", ready0); end
    data0 = 8'hC3;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_accept got %b expected 1", busy0); end
    measure(0, 1'b1, doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, bits, overlap);
    checks++; if (doneAt !== 35) begin errors++; $display("[TB] FAIL b2b_done2_at got %0d expected 35", doneAt); end
    checks++; if (cap0 !== 8'hC3) begin errors++; $display("[TB] FAIL b2b_rx2 got %h expected c3", cap0); end
    checks++; if (bits !== 16'h00C3) begin errors++; $display("[TB] FAIL b2b_bits2 got %h expected 00c3", bits); end
    valid0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_dropped got %b expected 0", busy0); end
  endtask

  task automatic test_reset_abort();
    int doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, overlap, lc;
    logic [15:0] bits;
    accept(0, 16'h00FF);
    repeat (17) begin @(posedge clk); #1; end
    checks++; if (sdata0 !== 1'b1) begin errors++; $display("[TB] FAIL abort_sdata_before got %b expected 1", sdata0); end
    lc = latchCnt0;
    rst = 1'b1;
    #1;
    checks++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready_busy got %b%b expected 10", ready0, busy0); end
    checks++; if (sdata0 !== 1'b0 || sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_sdata_sclk got %b%b expected 00", sdata0, sclk0); end
    checks++; if (latch0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_latch_done got %b%b expected 00", latch0, done0); end
    #2;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (latchCnt0 !== lc) begin errors++; $display("[TB] FAIL abort_no_latch got %0d expected %0d", latchCnt0, lc); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got %b expected 0", busy0); end
    accept(0, 16'h0012);
    measure(0, 1'b0, doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, bits, overlap);
    checks++; if (doneAt !== 35) begin errors++; $display("[TB] FAIL abort_next_done_at got %0d expected 35", doneAt); end
    checks++; if (bits !== 16'h0012) begin errors++; $display("[TB] FAIL abort_next_bits got %h expected 0012", bits); end
    checks++; if (cap0 !== 8'h12) begin errors++; $display("[TB] FAIL abort_next_rx got %h expected 12", cap0); end
  endtask

  task automatic test_wide();
    int doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, overlap;
    logic [15:0] bits;
    accept(2, 16'h8001);
    measure(2, 1'b0, doneAt, busyCyc, rises, minHigh, maxHigh, latchLen, bits, overlap);
    checks++; if (busyCyc !== 99) begin errors++; $display("[TB] FAIL wide_busy_cycles got %0d expected 99", busyCyc); end
    checks++; if (rises !== 16) begin errors++; $display("[TB] FAIL wide_sclk_rises got %0d expected 16", rises); end
    checks++; if (minHigh !== 3 || maxHigh !== 3) begin errors++; $display("[TB] FAIL wide_sclk_high got %0d..%0d expected 3..3", minHigh, maxHigh); end
    checks++; if (bits !== 16'h8001) begin errors++; $display("[TB] FAIL wide_bits got %h expected 8001", bits); end
    checks++; if (latchLen !== 3) begin errors++; $display("[TB] FAIL wide_latch_len got %0d expected 3", latchLen); end
    checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL wide_overlap got %0d expected 0", overlap); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    data0 = '0; data1 = '0; data2 = '0;
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    test_reset();
    test_basic();
    test_lsb_fast();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
